mjpeg_mmap_driver: RTL and testbench

Hardware initiator for the MJPEG accelerator's memory-mapped register port. It replaces firmware register pokes with a single command handshake. It programs the input offset, output offset and coefficient count, writes START, then polls FINISH until the job completes or a timeout fires. It connects directly to the accelerator's valid/ready/addr/wstrb/wdata/rdata slave port.

---
 rtl/mjpeg_mmap_driver_if.sv | 25 ++
 rtl/mjpeg_mmap_driver.sv | 226 ++++++++++++++++++++++
 tb/tb_mjpeg_mmap_driver.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mjpeg_mmap_driver_if.sv
// MJPEG accelerator memory-mapped register bus.
//
// Handshake: the master raises valid with addr/wstrb/wdata and holds all four
// stable until it samples ready=1 on a rising edge. ready is a one-cycle pulse
// from the slave. rdata is meaningful only in the ready cycle. After a ready,
// the master keeps valid low for at least one cycle so the slave can re-arm.
//
// Signals:
//   valid  master->slave  request present
//   addr   master->slave  byte address
//   wstrb  master->slave  4'hf = write, 4'h0 = read
//   wdata  master->slave  write data
//   ready  slave->master  acknowledge pulse
//   rdata  slave->master  read data, valid with ready
interface mjpeg_mmap_driver_if;
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/mjpeg_mmap_driver.sv
// Hardware initiator for the MJPEG accelerator register port. One accepted
// command programs INPUT_OFFSET, OUTPUT_OFFSET, NUM_COEF, writes START, then
// polls FINISH until bit 0 is set, a poll budget runs out, or a transaction
// goes unacknowledged for too long.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   job request handshake (ready only in IDLE)
//   cmd_input_offset      value for INPUT_OFFSET  (0x2c)
//   cmd_output_offset     value for OUTPUT_OFFSET (0x34)
//   cmd_num_coef          value for NUM_COEF      (0x04)
//   busy                  high whenever not IDLE
//   done / err            one-cycle completion / abort pulses
//   err_code              0 none, 1 ack timeout, 2 poll timeout
//   poll_count            FINISH reads issued in current/last job
//   dbg_state             current FSM state
//   mmap                  register bus master
module mjpeg_mmap_driver #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned MAX_POLLS   = 1024,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_input_offset,
  input  logic [31:0] cmd_output_offset,
  input  logic [6:0]  cmd_num_coef,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] poll_count,
  output logic [2:0]  dbg_state,
  mjpeg_mmap_driver_if.master mmap
);

  localparam logic [31:0] OFS_FINISH   = 32'h00;
  localparam logic [31:0] OFS_NUM_COEF = 32'h04;
  localparam logic [31:0] OFS_IN       = 32'h2c;
  localparam logic [31:0] OFS_OUT      = 32'h34;
  localparam logic [31:0] OFS_START    = 32'h38;

  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [15:0] POLL_MAX  = 16'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_IN, S_GAP, S_WR_OUT, S_WR_NUM, S_WR_START, S_POLL_RD, S_POLL_WAIT
  } state_t;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;        // state to enter after the one-cycle GAP
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] poll_count_q, poll_count_d;
  logic [31:0] out_ofs_q, out_ofs_d;
  logic [6:0]  num_coef_q, num_coef_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        ack_tmo;
  logic [15:0] poll_inc;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    poll_count_d = poll_count_q;
    out_ofs_d    = out_ofs_q;
    num_coef_d   = num_coef_q;
    ack_cnt_d    = ack_cnt_q;
    wait_cnt_d   = wait_cnt_q;

    // Counts cycles the current request has been outstanding; cleared
    // wherever valid is (re)raised below.
    ack_tmo = valid_q && !mmap.ready && (ack_cnt_q == ACK_LAST);
    if (valid_q && !mmap.ready) ack_cnt_d = ack_cnt_q + 16'd1;
    poll_inc = (poll_count_q == 16'hffff) ? poll_count_q : poll_count_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          out_ofs_d    = cmd_output_offset;
          num_coef_d   = cmd_num_coef;
          err_code_d   = 2'd0;
          poll_count_d = 16'd0;
          state_d      = S_WR_IN;
          valid_d      = 1'b1;
          addr_d       = BASE_ADDR + OFS_IN;
          wstrb_d      = 4'hf;
          wdata_d      = cmd_input_offset;
          ack_cnt_d    = 16'd0;
        end
      end
      S_WR_IN, S_WR_OUT, S_WR_NUM, S_WR_START: begin
        if (mmap.ready) begin
          valid_d = 1'b0;
          state_d = S_GAP;
          case (state_q)
            S_WR_IN:  ret_d = S_WR_OUT;
            S_WR_OUT: ret_d = S_WR_NUM;
            S_WR_NUM: ret_d = S_WR_START;
            default:  ret_d = S_POLL_RD;
          endcase
        end
      end
      S_GAP: begin
        state_d   = ret_q;
        valid_d   = 1'b1;
        ack_cnt_d = 16'd0;
        case (ret_q)
          S_WR_OUT: begin
            addr_d = BASE_ADDR + OFS_OUT;   wstrb_d = 4'hf; wdata_d = out_ofs_q;
          end
          S_WR_NUM: begin
            addr_d = BASE_ADDR + OFS_NUM_COEF; wstrb_d = 4'hf; wdata_d = {25'd0, num_coef_q};
          end
          S_WR_START: begin
            addr_d = BASE_ADDR + OFS_START; wstrb_d = 4'hf; wdata_d = 32'h1;
          end
          default: begin
            addr_d = BASE_ADDR + OFS_FINISH; wstrb_d = 4'h0; wdata_d = 32'h0;
          end
        endcase
      end
      S_POLL_RD: begin
        if (mmap.ready) begin
          valid_d      = 1'b0;
          poll_count_d = poll_inc;
          if (mmap.rdata[0]) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (poll_inc == POLL_MAX) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
            state_d    = S_IDLE;
          end else begin
            wait_cnt_d = 16'd0;
            state_d    = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: begin
        // valid stays low for exactly POLL_GAP cycles before the next read.
        if (wait_cnt_q == GAP_LAST) begin
          state_d   = S_POLL_RD;
          valid_d   = 1'b1;
          addr_d    = BASE_ADDR + OFS_FINISH;
          wstrb_d   = 4'h0;
          wdata_d   = 32'h0;
          ack_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ack_tmo) begin
      valid_d    = 1'b0;
      err_d      = 1'b1;
      err_code_d = 2'd1;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      valid_q      <= 1'b0;
      addr_q       <= 32'd0;
      wstrb_q      <= 4'd0;
      wdata_q      <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      poll_count_q <= 16'd0;
      out_ofs_q    <= 32'd0;
      num_coef_q   <= 7'd0;
      ack_cnt_q    <= 16'd0;
      wait_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      poll_count_q <= poll_count_d;
      out_ofs_q    <= out_ofs_d;
      num_coef_q   <= num_coef_d;
      ack_cnt_q    <= ack_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign poll_count  = poll_count_q;
  assign dbg_state   = state_q;
  assign mmap.valid  = valid_q;
  assign mmap.addr   = addr_q;
  assign mmap.wstrb  = wstrb_q;
  assign mmap.wdata  = wdata_q;

endmodule

// File: tb/tb_mjpeg_mmap_driver.sv
// Bench for mjpeg_mmap_driver: a delay-configurable slave model, a job-level
// reference model that pushes expected bus transactions and job results, and
// a monitor that pops and compares whenever the DUT completes a transaction
// or pulses done/err.
module tb_mjpeg_mmap_driver;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int POLL_GAP    = 4;
  localparam int MAX_POLLS   = 8;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_in = '0;
  logic [31:0] cmd_out = '0;
  logic [6:0]  cmd_num = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] poll_count;
  logic [2:0]  dbg_state;

  mjpeg_mmap_driver_if bus();

  mjpeg_mmap_driver #(
    .BASE_ADDR(BASE), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_input_offset(cmd_in), .cmd_output_offset(cmd_out), .cmd_num_coef(cmd_num),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .poll_count(poll_count),
    .dbg_state(dbg_state), .mmap(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [67:0] exp_q[$];   // {addr, wstrb, wdata}
  logic [21:0] res_q[$];   // {done, err, err_code, poll_count, cmd_ready, busy}

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int wdelay = 0, rdelay = 0, finish_on = 0, nak_idx = -1;
  int tx_idx = 0;
  int wcnt = 0;
  int s_d;
  logic [31:0] s_r;

  initial begin
    bus.ready = 1'b0;
    bus.rdata = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ready = 1'b0;
      wcnt = 0;
    end else begin
      #1;
      if (bus.ready) begin
        bus.ready = 1'b0;
        bus.rdata = '0;
        wcnt = 0;
      end else if (bus.valid) begin
        s_d = (bus.wstrb == 4'h0) ? rdelay : wdelay;
        if (tx_idx != nak_idx) begin
          if (wcnt >= s_d) begin
            bus.ready = 1'b1;
            if (bus.wstrb == 4'h0) begin
              s_r = $urandom();
              s_r[0] = (tx_idx - 3 == finish_on);  // 1-based FINISH read number
              bus.rdata = s_r;
            end
            tx_idx++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected job: four register writes, then FINISH reads until the
  // finish_on-th read (or MAX_POLLS reads); an unacknowledged transaction
  // at index nak cuts the job short with an ack timeout.
  task automatic push_job(input logic [31:0] i, input logic [31:0] o, input logic [6:0] n,
                          input int fin, input int nak);
    logic [67:0] tx[$];
    int nreads;
    nreads = (fin >= 1 && fin <= MAX_POLLS) ? fin : MAX_POLLS;
    tx.push_back({BASE + 32'h2c, 4'hf, i});
    tx.push_back({BASE + 32'h34, 4'hf, o});
    tx.push_back({BASE + 32'h04, 4'hf, {25'd0, n}});
    tx.push_back({BASE + 32'h38, 4'hf, 32'h1});
    for (int r = 0; r < nreads; r++) tx.push_back({BASE, 4'h0, 32'h0});
    for (int k = 0; k < tx.size(); k++) begin
      if (k == nak) begin
        res_q.push_back({1'b0, 1'b1, 2'd1, 16'((k > 4) ? k - 4 : 0), 1'b1, 1'b0});
        return;
      end
      exp_q.push_back(tx[k]);
    end
    if (fin >= 1 && fin <= MAX_POLLS)
      res_q.push_back({1'b1, 1'b0, 2'd0, 16'(nreads), 1'b1, 1'b0});
    else
      res_q.push_back({1'b0, 1'b1, 2'd2, 16'(MAX_POLLS), 1'b1, 1'b0});
  endtask

  // ---------------- monitor ----------------
  logic        prev_v = 1'b0, prev_rdy = 1'b0, had_tx = 1'b0, last_rd = 1'b0, accept_pend = 1'b0;
  int          hi_run = 0, low_run = 0;
  logic [67:0] prev_tx = '0;
  logic [67:0] act_tx;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0; prev_rdy = 0; had_tx = 0; accept_pend = 0; hi_run = 0; low_run = 0;
    end else begin
      if (accept_pend) begin
        chk("first_valid_after_accept", {busy, bus.valid}, 2'b11);
        accept_pend = 0;
      end
      if (cmd_valid && cmd_ready) begin
        accept_pend = 1;
        had_tx = 0;
        tx_idx = 0;
      end
      act_tx = {bus.addr, bus.wstrb, bus.wdata};
      if (bus.valid) begin
        if (!prev_v) begin
          if (had_tx) chk("gap_len", low_run, last_rd ? POLL_GAP : 1);
          hi_run = 0;
        end else if (!prev_rdy) begin
          chk("hold_stable", act_tx, prev_tx);
        end
        hi_run++;
        low_run = 0;
        prev_tx = act_tx;
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx: got %0h expected none", act_tx);
          end else begin
            chk("tx", act_tx, exp_q.pop_front());
          end
          had_tx = 1;
          last_rd = (bus.wstrb == 4'h0);
        end
      end else begin
        if (prev_v && !prev_rdy) chk("ack_timeout_len", hi_run, ACK_TIMEOUT);
        low_run++;
      end
      if (done || err) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got done=%0b err=%0b expected none", done, err);
        end else begin
          chk("job_result", {done, err, err_code, poll_count, cmd_ready, busy}, res_q.pop_front());
        end
      end
      prev_v = bus.valid;
      prev_rdy = bus.ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_reset_outputs(input string name);
    chk(name, {bus.valid, bus.addr, bus.wstrb, bus.wdata, busy, done, err, err_code, poll_count, cmd_ready},
        {1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1});
  endtask

  task automatic set_slave(input int fin, input int wd, input int rd, input int nak);
    finish_on = fin; wdelay = wd; rdelay = rd; nak_idx = nak;
  endtask

  // Present a command at a negedge; returns after the accepting posedge.
  task automatic issue(input logic [31:0] i, input logic [31:0] o, input logic [6:0] n);
    int k;
    @(negedge clk);
    cmd_in = i; cmd_out = o; cmd_num = n; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(done || err) && k < 3000);
    chk("job_end_seen", done | err, 1'b1);
  endtask

  task automatic run_job(input logic [31:0] i, input logic [31:0] o, input logic [6:0] n,
                         input int fin, input int wd, input int rd, input int nak);
    set_slave(fin, wd, rd, nak);
    push_job(i, o, n, fin, nak);
    issue(i, o, n);
    cmd_valid = 1'b0;
    wait_end();
  endtask

  // ---------------- main stimulus ----------------
  int k;
  logic [31:0] ri, ro;
  logic [6:0]  rn;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_values");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal: finish on third read.
    run_job(32'h100, 32'h2000, 7'd64, 3, 0, 0, -1);
    chk("nominal_poll_count", poll_count, 16'd3);

    // Slow slave on writes.
    run_job($urandom(), $urandom(), 7'($urandom_range(0, 127)), 2, 5, 0, -1);

    // NUM_COEF write never acknowledged.
    run_job(32'hA5A5_0000, 32'h5A5A_0000, 7'd17, 1, 0, 0, 2);
    repeat (3) @(negedge clk);
    chk("err_code_held", {err_code, cmd_ready, busy}, {2'd1, 1'b1, 1'b0});
    set_slave(0, 0, 0, -1);

    // FINISH never set: poll timeout after MAX_POLLS reads.
    run_job(32'h1, 32'h2, 7'd3, 0, 0, 1, -1);

    // cmd_valid held through a job with other operands.
    set_slave(2, 1, 0, -1);
    push_job(32'h1111_1111, 32'h2222_2222, 7'd11, 2, -1);
    push_job(32'h3333_3333, 32'h4444_4444, 7'd99, 2, -1);
    issue(32'h1111_1111, 32'h2222_2222, 7'd11);
    cmd_in = 32'h3333_3333; cmd_out = 32'h4444_4444; cmd_num = 7'd99;
    wait_end();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_end();

    // Reset while a FINISH read is outstanding.
    set_slave(0, 0, 2, -1);
    push_job(32'hDEAD_0000, 32'hBEEF_0000, 7'd5, 0, -1);
    issue(32'hDEAD_0000, 32'hBEEF_0000, 7'd5);
    cmd_valid = 1'b0;
    k = 0;
    while (!(bus.valid && bus.wstrb == 4'h0 && poll_count >= 16'd1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("reached_poll_read", bus.valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_poll");
    exp_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(32'h100, 32'h2000, 7'd64, 3, 0, 0, -1);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      ri = $urandom();
      ro = $urandom();
      rn = 7'($urandom_range(0, 127));
      run_job(ri, ro, rn, $urandom_range(0, MAX_POLLS), $urandom_range(0, 4), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
